// File: rtl/tetris_pkg.sv
// ============================================================================
// Module : tetris_pkg
// Brief  : Shared state encoding, piece-type codes and row-finder constants
//          for the tetris game-sequencing core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tetris_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_DROP     = 3'd2,
    S_UPDATE   = 3'd3,
    S_CLEAR    = 3'd4,
    S_GAMEOVER = 3'd5
  } state_t;

  localparam logic [2:0] C_PIECE_O = 3'd0;
  localparam logic [2:0] C_PIECE_I = 3'd1;
  localparam logic [2:0] C_PIECE_T = 3'd2;
  localparam logic [2:0] C_PIECE_S = 3'd3;
  localparam logic [2:0] C_PIECE_Z = 3'd4;
  localparam logic [2:0] C_PIECE_J = 3'd5;
  localparam logic [2:0] C_PIECE_L = 3'd6;
  localparam logic [2:0] C_PIECE_X = 3'd7;

  localparam int C_NO_ROW = 31;

endpackage

`default_nettype wire

// File: rtl/tetromino_shape_decoder.sv
// ============================================================================
// Module : tetromino_shape_decoder
// Brief  : Combinational pivot/type/rotation to four cell coordinates.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tetromino_shape_decoder
  import tetris_pkg::*;
(
  input  logic [3:0] i_x,
  input  logic [4:0] i_y,
  input  logic [2:0] i_block_type,
  input  logic [1:0] i_rotation,
  output logic [3:0] o_x1,
  output logic [4:0] o_y1,
  output logic [3:0] o_x2,
  output logic [4:0] o_y2,
  output logic [3:0] o_x3,
  output logic [4:0] o_y3,
  output logic [3:0] o_x4,
  output logic [4:0] o_y4
);

  logic signed [2:0] w_dx [3];
  logic signed [2:0] w_dy [3];
  logic signed [2:0] w_rx [3];
  logic signed [2:0] w_ry [3];
  logic [3:0]        w_cx [3];
  logic [4:0]        w_cy [3];
  logic [1:0]        w_rot;

  always_comb begin
    w_dx[0] = 3'sd1;  w_dy[0] = 3'sd0;
    w_dx[1] = 3'sd0;  w_dy[1] = -3'sd1;
    w_dx[2] = 3'sd1;  w_dy[2] = -3'sd1;
    w_rot   = i_rotation;
    case (i_block_type)
      C_PIECE_I: begin
        w_dx[0] = -3'sd1; w_dy[0] = 3'sd0;
        w_dx[1] = 3'sd1;  w_dy[1] = 3'sd0;
        w_dx[2] = 3'sd2;  w_dy[2] = 3'sd0;
      end
      C_PIECE_T: begin
        w_dx[0] = -3'sd1; w_dy[0] = 3'sd0;
        w_dx[1] = 3'sd1;  w_dy[1] = 3'sd0;
        w_dx[2] = 3'sd0;  w_dy[2] = 3'sd1;
      end
      C_PIECE_S: begin
        w_dx[0] = -3'sd1; w_dy[0] = 3'sd0;
        w_dx[1] = 3'sd0;  w_dy[1] = 3'sd1;
        w_dx[2] = 3'sd1;  w_dy[2] = 3'sd1;
      end
      C_PIECE_Z: begin
        w_dx[0] = 3'sd1;  w_dy[0] = 3'sd0;
        w_dx[1] = 3'sd0;  w_dy[1] = 3'sd1;
        w_dx[2] = -3'sd1; w_dy[2] = 3'sd1;
      end
      C_PIECE_J: begin
        w_dx[0] = -3'sd1; w_dy[0] = 3'sd0;
        w_dx[1] = 3'sd1;  w_dy[1] = 3'sd0;
        w_dx[2] = -3'sd1; w_dy[2] = 3'sd1;
      end
      C_PIECE_L: begin
        w_dx[0] = -3'sd1; w_dy[0] = 3'sd0;
        w_dx[1] = 3'sd1;  w_dy[1] = 3'sd0;
        w_dx[2] = 3'sd1;  w_dy[2] = 3'sd1;
      end
      // O and the spare code 7 share one footprint that rotation must not move
      default: w_rot = 2'd0;
    endcase
  end

  generate
    for (genvar k = 0; k < 3; k++) begin : g_cell
      always_comb begin
        case (w_rot)
          2'd1:    begin w_rx[k] = w_dy[k];  w_ry[k] = -w_dx[k]; end
          2'd2:    begin w_rx[k] = -w_dx[k]; w_ry[k] = -w_dy[k]; end
          2'd3:    begin w_rx[k] = -w_dy[k]; w_ry[k] = w_dx[k];  end
          default: begin w_rx[k] = w_dx[k];  w_ry[k] = w_dy[k];  end
        endcase
      end
      // Wrap-around is intentional: the parent flags x>=10 / y>=23 as off-board
      assign w_cx[k] = i_x + {w_rx[k][2], w_rx[k]};
      assign w_cy[k] = i_y + {{2{w_ry[k][2]}}, w_ry[k]};
    end
  endgenerate

  assign o_x1 = i_x;
  assign o_y1 = i_y;
  assign o_x2 = w_cx[0];
  assign o_y2 = w_cy[0];
  assign o_x3 = w_cx[1];
  assign o_y3 = w_cy[1];
  assign o_x4 = w_cx[2];
  assign o_y4 = w_cy[2];

endmodule

`default_nettype wire

// File: rtl/tetris_game_core.sv
// ============================================================================
// Module : tetris_game_core
// Brief  : Game-flow FSM, lowest-complete-row finder and piece shape decode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tetris_game_core
  import tetris_pkg::*;
#(
  parameter int ROWS   = 20,
  parameter int NO_ROW = C_NO_ROW
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            start_game,
  input  logic            filled_under,
  input  logic            overflow,
  input  logic [ROWS-1:0] completed_lines,
  input  logic [3:0]      x,
  input  logic [4:0]      y,
  input  logic [2:0]      block_type,
  input  logic [2:0]      rotation,
  output logic            load_block,
  output logic            drop_block,
  output logic            update_board_state,
  output logic            shift_down,
  output logic            game_over,
  output logic [4:0]      cleared_index,
  output logic [3:0]      x1,
  output logic [4:0]      y1,
  output logic [3:0]      x2,
  output logic [4:0]      y2,
  output logic [3:0]      x3,
  output logic [4:0]      y3,
  output logic [3:0]      x4,
  output logic [4:0]      y4
);

  state_t r_state;
  state_t w_next;
  logic   r_load, r_drop, r_update, r_in_clear, r_game_over;
  logic   w_any_full;
  logic [4:0] w_idx;

  assign w_any_full = |completed_lines;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start_game) w_next = S_LOAD;
      S_LOAD:     w_next = S_DROP;
      S_DROP:     if (filled_under) w_next = S_UPDATE;
      S_UPDATE:   w_next = S_CLEAR;
      S_CLEAR:    if (!w_any_full) w_next = overflow ? S_GAMEOVER : S_LOAD;
      S_GAMEOVER: w_next = S_GAMEOVER;
      default:    w_next = S_IDLE;
    endcase
  end

  // Control flags are registered from the next state so they line up with it
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_load      <= 1'b0;
      r_drop      <= 1'b0;
      r_update    <= 1'b0;
      r_in_clear  <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_load      <= (w_next == S_LOAD);
      r_drop      <= (w_next == S_DROP);
      r_update    <= (w_next == S_UPDATE);
      r_in_clear  <= (w_next == S_CLEAR);
      r_game_over <= (w_next == S_GAMEOVER);
    end
  end

  assign load_block         = r_load;
  assign drop_block         = r_drop;
  assign update_board_state = r_update;
  assign shift_down         = r_in_clear & w_any_full;
  assign game_over          = r_game_over;

  // Scan top-down so the lowest full row overwrites any higher one
  always_comb begin
    w_idx = 5'(NO_ROW);
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (completed_lines[r]) w_idx = 5'(r);
    end
  end

  assign cleared_index = w_idx;

  tetromino_shape_decoder u_shape (
    .i_x          (x),
    .i_y          (y),
    .i_block_type (block_type),
    .i_rotation   (rotation[1:0]),
    .o_x1         (x1),
    .o_y1         (y1),
    .o_x2         (x2),
    .o_y2         (y2),
    .o_x3         (x3),
    .o_y3         (y3),
    .o_x4         (x4),
    .o_y4         (y4)
  );

endmodule

`default_nettype wire

// File: tb/tb_tetris_game_core.sv
// ============================================================================
// Module : tb_tetris_game_core
// Brief  : Directed self-checking bench for the tetris game-sequencing core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tetris_game_core;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start_game, filled_under, overflow;
  logic [19:0] completed_lines;
  logic [3:0]  x;
  logic [4:0]  y;
  logic [2:0]  block_type, rotation;
  logic        load_block, drop_block, update_board_state, shift_down, game_over;
  logic [4:0]  cleared_index;
  logic [3:0]  x1, x2, x3, x4;
  logic [4:0]  y1, y2, y3, y4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  tetris_game_core #(.ROWS(20), .NO_ROW(31)) dut (
    .clock              (clock),
    .resetn             (resetn),
    .start_game         (start_game),
    .filled_under       (filled_under),
    .overflow           (overflow),
    .completed_lines    (completed_lines),
    .x                  (x),
    .y                  (y),
    .block_type         (block_type),
    .rotation           (rotation),
    .load_block         (load_block),
    .drop_block         (drop_block),
    .update_board_state (update_board_state),
    .shift_down         (shift_down),
    .game_over          (game_over),
    .cleared_index      (cleared_index),
    .x1 (x1), .y1 (y1), .x2 (x2), .y2 (y2),
    .x3 (x3), .y3 (y3), .x4 (x4), .y4 (y4)
  );

  typedef struct {
    logic [2:0]  btype;
    logic [2:0]  rot;
    logic [3:0]  px;
    logic [4:0]  py;
    logic [35:0] cells;  // {x1,y1,x2,y2,x3,y3,x4,y4}
  } shape_vec_t;

  typedef struct {
    logic [19:0] lines;
    logic [4:0]  idx;
  } row_vec_t;

  function automatic logic [35:0] pack_cells(int ax1, int ay1, int ax2, int ay2,
                                             int ax3, int ay3, int ax4, int ay4);
    return {4'(ax1), 5'(ay1), 4'(ax2), 5'(ay2), 4'(ax3), 5'(ay3), 4'(ax4), 5'(ay4)};
  endfunction

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {load, drop, update, shift, game_over}
  function automatic logic [35:0] ctrl();
    return 36'({load_block, drop_block, update_board_state, shift_down, game_over});
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  shape_vec_t svec [12];
  row_vec_t   rvec [5];

  initial begin
    resetn = 1'b0; start_game = 1'b0; filled_under = 1'b0; overflow = 1'b0;
    completed_lines = '0; x = '0; y = '0; block_type = '0; rotation = '0;

    svec[0]  = '{3'd2, 3'd0, 4'd4, 5'd19, pack_cells(4,19, 3,19, 5,19, 4,20)};
    svec[1]  = '{3'd2, 3'd1, 4'd4, 5'd19, pack_cells(4,19, 4,20, 4,18, 5,19)};
    svec[2]  = '{3'd2, 3'd2, 4'd4, 5'd10, pack_cells(4,10, 5,10, 3,10, 4,9)};
    svec[3]  = '{3'd1, 3'd1, 4'd0, 5'd0,  pack_cells(0,0, 0,1, 0,31, 0,30)};
    svec[4]  = '{3'd1, 3'd0, 4'd0, 5'd0,  pack_cells(0,0, 15,0, 1,0, 2,0)};
    svec[5]  = '{3'd4, 3'd3, 4'd5, 5'd5,  pack_cells(5,5, 5,6, 4,5, 4,4)};
    svec[6]  = '{3'd0, 3'd2, 4'd3, 5'd7,  pack_cells(3,7, 4,7, 3,6, 4,6)};
    svec[7]  = '{3'd7, 3'd1, 4'd3, 5'd7,  pack_cells(3,7, 4,7, 3,6, 4,6)};
    svec[8]  = '{3'd6, 3'd0, 4'd4, 5'd2,  pack_cells(4,2, 3,2, 5,2, 5,3)};
    svec[9]  = '{3'd3, 3'd1, 4'd6, 5'd8,  pack_cells(6,8, 6,9, 7,8, 7,7)};
    svec[10] = '{3'd5, 3'd2, 4'd6, 5'd8,  pack_cells(6,8, 7,8, 5,8, 7,7)};
    svec[11] = '{3'd2, 3'd5, 4'd4, 5'd19, pack_cells(4,19, 4,20, 4,18, 5,19)};

    rvec[0] = '{20'h00000, 5'd31};
    rvec[1] = '{20'h80000, 5'd19};
    rvec[2] = '{20'h80001, 5'd0};
    rvec[3] = '{20'h0A000, 5'd13};
    rvec[4] = '{20'h00100, 5'd8};

    for (int i = 0; i < 12; i++) begin
      block_type = svec[i].btype; rotation = svec[i].rot;
      x = svec[i].px; y = svec[i].py;
      #1;
      check($sformatf("shape[%0d]", i), {x1, y1, x2, y2, x3, y3, x4, y4}, svec[i].cells);
    end
    for (int i = 0; i < 5; i++) begin
      completed_lines = rvec[i].lines;
      #1;
      check($sformatf("row_idx[%0d]", i), 36'(cleared_index), 36'(rvec[i].idx));
    end
    completed_lines = '0;

    #6 resetn = 1'b1;
    #1 check("reset_ctrl", ctrl(), 36'b00000);
    for (int i = 0; i < 5; i++) tick();
    check("idle_hold", ctrl(), 36'b00000);

    start_game = 1'b1;
    tick(); check("load", ctrl(), 36'b10000);
    start_game = 1'b0;
    tick(); check("drop1", ctrl(), 36'b01000);
    tick(); check("drop2", ctrl(), 36'b01000);
    tick(); check("drop3", ctrl(), 36'b01000);
    filled_under = 1'b1;
    tick(); check("update", ctrl(), 36'b00100);
    filled_under = 1'b0;
    completed_lines = 20'h00012;
    tick(); check("clear_shift", ctrl(), 36'b00010);
    check("clear_idx1", 36'(cleared_index), 36'd1);
    completed_lines = 20'h00010;
    #1 check("clear_idx4", 36'(cleared_index), 36'd4);
    tick(); check("clear_stay", ctrl(), 36'b00010);
    completed_lines = '0;
    #1 check("clear_done", ctrl(), 36'b00000);
    check("clear_norow", 36'(cleared_index), 36'd31);
    tick(); check("reload", ctrl(), 36'b10000);
    tick(); check("drop_again", ctrl(), 36'b01000);
    filled_under = 1'b1;
    tick(); check("update2", ctrl(), 36'b00100);
    filled_under = 1'b0; overflow = 1'b1;
    tick(); check("clear_empty", ctrl(), 36'b00000);
    tick(); check("gameover", ctrl(), 36'b00001);
    start_game = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("gameover_hold", ctrl(), 36'b00001);
    resetn = 1'b0;
    #2 check("gameover_reset", ctrl(), 36'b00000);
    overflow = 1'b0; start_game = 1'b0;
    tick(); resetn = 1'b1;

    start_game = 1'b1;
    tick(); check("load_b", ctrl(), 36'b10000);
    start_game = 1'b0;
    tick(); check("drop_b", ctrl(), 36'b01000);
    #2 resetn = 1'b0;
    #1 check("async_reset", ctrl(), 36'b00000);
    #1 resetn = 1'b1;
    tick(); check("idle_after_rst", ctrl(), 36'b00000);
    start_game = 1'b1;
    tick(); check("load_from_idle", ctrl(), 36'b10000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tetris_game_core.md
Name: tetris_game_core

Overview:
- Game-sequencing core of the tetris datapath, clocked on the slow block-fall clock.
- Contains three functions:
  - the game-flow FSM (spawn, fall, lock, line-clear, game over);
  - a lowest-completed-row finder;
  - a combinational tetromino shape decoder that turns pivot position, type and rotation into four cell coordinates.
- The board, movement and rendering stay in the parent datapath.

Parameters:
- ROWS, 20, number of playable rows checked for completion.
- NO_ROW, 31, cleared_index value when no row is complete.

Ports:
- clock  in  1  block-fall clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start_game  in  1  leaves IDLE when high.
- filled_under  in  1  piece rests on floor or on a locked cell.
- overflow  in  1  a locked cell exists in rows 20..22.
- completed_lines  in  20  bit r = row r is full.
- x  in  4  pivot column.
- y  in  5  pivot row (row 0 = bottom).
- block_type  in  3  piece type.
- rotation  in  3  rotation; only bits [1:0] are used.
- load_block  out  1  spawn new piece.
- drop_block  out  1  piece may fall.
- update_board_state  out  1  write piece into board.
- shift_down  out  1  collapse the completed row.
- game_over  out  1  game lost.
- cleared_index  out  5  lowest complete row, or NO_ROW.
- x1,y1,x2,y2,x3,y3,x4,y4  out  4/5 each  cell coordinates of the piece.

Behaviour:
- FSM is Moore; outputs are registered, one-hot per state, and at most one control output is high.
- Reset (asynchronous) forces state IDLE and all five control outputs to 0 immediately.
- IDLE: all outputs 0.
  - start_game=1 -> LOAD.
- LOAD: load_block=1 for exactly one cycle.
  - -> DROP.
- DROP: drop_block=1.
  - filled_under=0 -> stay in DROP.
  - filled_under=1 -> UPDATE.
- UPDATE: update_board_state=1 for exactly one cycle.
  - -> CLEAR.
- CLEAR: shift_down=1 while completed_lines != 0.
  - Stay in CLEAR while completed_lines != 0.
  - When completed_lines == 0, leave at the next edge with shift_down=0 that cycle:
    - overflow=1 -> GAMEOVER;
    - otherwise -> LOAD.
  - Multiple full rows are collapsed one at a time by the parent within this state.
- GAMEOVER: game_over=1.
  - Absorbing state; only resetn exits it. start_game is ignored here.
- cleared_index (combinational):
  - equals the index of the lowest set bit of completed_lines, 0..19;
  - equals NO_ROW (31) when all bits are 0;
  - the lower index wins when several bits are set.
- Shape decoder (combinational, no latency):
  - cell1 is always the pivot (x,y).
  - Cells 2..4 are pivot + offset (dx,dy), with y increasing upward.
  - Rotation-0 offsets for cells 2,3,4:
    - type 0 O: (1,0) (0,-1) (1,-1); identical for all rotations.
    - type 1 I: (-1,0) (1,0) (2,0).
    - type 2 T: (-1,0) (1,0) (0,1).
    - type 3 S: (-1,0) (0,1) (1,1).
    - type 4 Z: (1,0) (0,1) (-1,1).
    - type 5 J: (-1,0) (1,0) (-1,1).
    - type 6 L: (-1,0) (1,0) (1,1).
    - type 7: identical to type 0.
  - Clockwise rotation applied rotation[1:0] times:
    - r1: (dx,dy) -> (dy,-dx);
    - r2: (-dx,-dy);
    - r3: (-dy,dx).
  - Arithmetic is modulo the port width: x is 4-bit, y is 5-bit.
    - x=0 with dx=-1 yields 15; y=0 with dy=-1 yields 31.
    - The parent relies on these wrapped values to detect out-of-bounds cells (x>=10, y>=23); the decoder must not clamp or saturate.

Decomposition:
- Package tetris_pkg:
  - state encoding (IDLE, LOAD, DROP, UPDATE, CLEAR, GAMEOVER);
  - piece-type constants 0..7;
  - NO_ROW.
- One natural sub-module: tetromino_shape_decoder (pure combinational offset table plus rotation).
- The row finder is a small inline priority encoder in the top.

Test Plan:
- Reset, hold start_game=0 for 5 cycles -> all outputs 0. Then start_game=1 -> next cycle load_block=1, following cycle drop_block=1.
- In DROP: filled_under=0 for 3 cycles, then 1 -> drop_block stays high 3 cycles, then update_board_state=1 for one cycle, then CLEAR.
- In CLEAR: completed_lines=20'h00012 -> shift_down=1, cleared_index=1. Change to 20'h00010 -> cleared_index=4. Change to 0 -> shift_down=0; with overflow=0 next state LOAD, with overflow=1 next state GAMEOVER (game_over=1, persists with start_game=1 until resetn=0).
- Shape decoder, x=4, y=19, type=2, rotation=0 -> cells (4,19)(3,19)(5,19)(4,20). Same with rotation=1 -> (4,19)(4,20)(4,18)(5,19).
- Wrap check, type=1, x=0, y=0, rotation=1 -> cells (0,0)(0,1)(0,31)(0,30). Same with x=0, rotation=0 -> x2=15.
- Async reset mid-DROP: resetn low between clock edges -> drop_block falls to 0 without waiting for a clock edge; state IDLE after release.
